ring_counter: RTL and testbench

- Parameterised ring counter: a WIDTH-bit register, loaded with a caller-supplied pattern, that rotates by one position every clock.
- With a one-hot pattern it produces a sequence of one-hot phase or select strobes that repeats every WIDTH cycles.
- Used as a lightweight sequencer or strobe generator. Any pattern is legal; it is rotated unchanged.

---
 rtl/ring_counter.sv | 63 ++++++
 tb/tb_ring_counter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ring_counter.sv
// WIDTH-bit rotating ring counter with an asynchronous, data-following load of init.
// Optional RING_COUNTER_SELFCORRECT_EN reloads the ring when it has collapsed to all-zero.

module ring_counter_cell (
   input  logic clk,
   input  logic set,
   input  logic clr,
   input  logic d,
   output logic q
);
   // Separate async set/clear rather than one async reset, so a change
   // on init while reset is held still reaches the flop.
   always_ff @(posedge clk or posedge set or posedge clr) begin
      if (clr)      q <= 1'b0;
      else if (set) q <= 1'b1;
      else          q <= d;
   end
endmodule

module ring_counter #(
   parameter int WIDTH      = 4,
   parameter int SHIFT_LEFT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] init,
   output logic [WIDTH-1:0] out
);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] rot;
   logic [WIDTH-1:0] nxt;

   generate
      if (SHIFT_LEFT != 0) begin : g_left
         assign rot = {q[WIDTH-2:0], q[WIDTH-1]};
      end else begin : g_right
         assign rot = {q[0], q[WIDTH-1:1]};
      end
   endgenerate

`ifdef RING_COUNTER_SELFCORRECT_EN
   logic [WIDTH-1:0] seed;
   // An all-zero init would reload all-zero forever; fall back to 0...01.
   assign seed = (init == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : init;
   assign nxt  = (q == '0) ? seed : rot;
`else
   assign nxt  = rot;
`endif

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         ring_counter_cell u_cell (
            .clk (clk),
            .set (reset &  init[i]),
            .clr (reset & ~init[i]),
            .d   (nxt[i]),
            .q   (q[i])
         );
      end
   endgenerate

   assign out = q;
endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench: three ring_counter configurations against a rotate-by-k reference model.
module tb_ring_counter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] ia = 4'h0, ib = 4'h0;
   logic [7:0] ic = 8'h0;
   logic [3:0] oa, ob;
   logic [7:0] oc;
   int         k = 0;
   int         tests = 0, fails = 0;

`ifdef RING_COUNTER_SELFCORRECT_EN
   localparam bit SC = 1'b1;
`else
   localparam bit SC = 1'b0;
`endif

   always #5 clk = ~clk;

   ring_counter #(.WIDTH(4), .SHIFT_LEFT(1)) dut_a (.clk(clk), .reset(rst), .init(ia), .out(oa));
   ring_counter #(.WIDTH(4), .SHIFT_LEFT(0)) dut_b (.clk(clk), .reset(rst), .init(ib), .out(ob));
   ring_counter #(.WIDTH(8), .SHIFT_LEFT(1)) dut_c (.clk(clk), .reset(rst), .init(ic), .out(oc));

   // Pattern after k post-reset edges: init rotated k places (mod w).
   function automatic logic [31:0] model(logic [31:0] init, int w, bit left, int kk);
      logic [31:0] mask, v;
      int          s;
      mask = (32'h1 << w) - 1;
      v    = init & mask;
      if (SC && v == 0) begin
         if (kk == 0) return 32'h0;
         v  = 32'h1;
         kk = kk - 1;
      end
      s = kk % w;
      if (s == 0) return v;
      if (left) return ((v << s) | (v >> (w - s))) & mask;
      return ((v >> s) | (v << (w - s))) & mask;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   task automatic chk_all(string tag);
      chk({tag, "_a"}, 32'(oa), model(32'(ia), 4, 1'b1, k));
      chk({tag, "_b"}, 32'(ob), model(32'(ib), 4, 1'b0, k));
      chk({tag, "_c"}, 32'(oc), model(32'(ic), 8, 1'b1, k));
   endtask

   // One clock; reset is sampled at the edge, outputs checked at the falling edge.
   task automatic tick(string tag);
      @(posedge clk);
      if (!rst) k++;
      @(negedge clk);
      chk_all(tag);
   endtask

   initial begin
      // reset assertion loads init without a clock edge
      ia = 4'b0010; ib = 4'b0010; ic = 8'h01;
      #1 rst = 1'b1;
      #1 chk_all("rst_async");
      chk("rst_const", 32'(oa), 32'h2);
      tick("rst_edge");
      rst = 1'b0; k = 0;
      for (int i = 1; i <= 17; i++) begin
         tick("run");
         if (i == 7) chk("w8_e7", 32'(oc), 32'h80);
         if (i == 8) chk("w8_e8", 32'(oc), 32'h01);
         if (i == 1) chk("right_e1", 32'(ob), 32'h1);
      end
      chk("left_e17", 32'(oa), 32'h4);

      // async reset between edges, then init changes while held
      #2 rst = 1'b1; k = 0;
      #1 chk_all("mid_rst");
      ia = 4'b1001; ic = 8'h5a;
      #1 chk_all("init_follow");
      chk("init_follow_c", 32'(oa), 32'h9);
      tick("rst_hold");
      tick("rst_hold2");

      // multi-bit, all-one, all-zero patterns
      for (int p = 0; p < 3; p++) begin
         rst = 1'b1; k = 0;
         ia = (p == 0) ? 4'b0110 : (p == 1) ? 4'b1111 : 4'b0000;
         ib = ia; ic = {ia, ia};
         #1 chk_all("pat_rst");
         @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < 9; i++) begin
            tick("pat");
            if (p == 0) chk("popcnt", 32'($countones(oa)), 32'd2);
         end
         if (p == 2 && !SC) chk("zero_stays", 32'(oa), 32'h0);
      end

      // randomized inits, run lengths and mid-run resets
      for (int r = 0; r < 40; r++) begin
         rst = 1'b1; k = 0;
         ia = 4'($urandom); ib = 4'($urandom); ic = 8'($urandom);
         #1 chk_all("rnd_rst");
         if ($urandom_range(0, 1) == 1) tick("rnd_hold");
         @(negedge clk);
         rst = 1'b0;
         for (int i = $urandom_range(1, 20); i > 0; i--) tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
